// File: rtl/pwrseq_cpu_rail_resp.sv
// Power-sequence responder for the cpus side: two independent rail channels (CPU, MEM)
// that drive VR enables and return qualified power-good and latched fault status.
module pwrseq_cpu_rail_resp #(
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned RAMP_TMO = 100
) (
  input  logic       CLK,
  input  logic       ResetN,
  input  logic       CPU_PwrEN,
  input  logic       MEM_PwrEN,
  input  logic       goOut_fltSt,
  input  logic       CPU_VrPG,
  input  logic       MEM_VrPG,
  output logic       CPU_VrEN,
  output logic       MEM_VrEN,
  output logic       CPU_PwrGD,
  output logic       MEM_PwrGD,
  output logic       CPU_PwrFLT,
  output logic       MEM_PwrFLT,
  output logic [1:0] CPU_FltCause,
  output logic [1:0] MEM_FltCause
);

  localparam int unsigned TW = $clog2(RAMP_TMO + 1);
  localparam logic [TW-1:0] DebLast = TW'(DEB_CYC - 1);
  localparam logic [TW-1:0] TmoLast = TW'(RAMP_TMO - 1);
  localparam logic [TW-1:0] CntMax  = '1;

  localparam logic [1:0] CauseNone = 2'b00;
  localparam logic [1:0] CauseTmo  = 2'b01;
  localparam logic [1:0] CauseDrop = 2'b10;

  typedef enum logic [1:0] {StOff, StRamp, StOn, StFault} state_e;

  // Index 0 is the CPU rail, index 1 the MEM rail.
  state_e        state_q [2];
  state_e        state_d [2];
  logic [TW-1:0] deb_q   [2];
  logic [TW-1:0] deb_d   [2];
  logic [TW-1:0] tmo_q   [2];
  logic [TW-1:0] tmo_d   [2];
  logic [1:0]    cause_q [2];
  logic [1:0]    cause_d [2];

  logic [1:0] sync1_q, pgs_q;
  logic [1:0] vr_en_q, vr_en_d;
  logic [1:0] pwr_gd_q, pwr_gd_d;
  logic [1:0] flt_q, flt_d;
  logic [1:0] en, pg_raw;

  assign en     = {MEM_PwrEN, CPU_PwrEN};
  assign pg_raw = {MEM_VrPG, CPU_VrPG};

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      state_d[r] = state_q[r];
      deb_d[r]   = deb_q[r];
      tmo_d[r]   = tmo_q[r];
      cause_d[r] = cause_q[r];

      unique case (state_q[r])
        StOff: begin
          if (en[r] && !goOut_fltSt) state_d[r] = StRamp;
        end
        StRamp: begin
          tmo_d[r] = (tmo_q[r] == CntMax) ? tmo_q[r] : tmo_q[r] + TW'(1);
          if (pgs_q[r]) deb_d[r] = (deb_q[r] == CntMax) ? deb_q[r] : deb_q[r] + TW'(1);
          else          deb_d[r] = '0;
          // Disable beats qualification, qualification beats timeout.
          if (!en[r]) begin
            state_d[r] = StOff;
          end else if (pgs_q[r] && deb_q[r] == DebLast) begin
            state_d[r] = StOn;
          end else if (tmo_q[r] == TmoLast) begin
            state_d[r] = StFault;
            cause_d[r] = CauseTmo;
          end
        end
        StOn: begin
          if (!pgs_q[r]) deb_d[r] = (deb_q[r] == CntMax) ? deb_q[r] : deb_q[r] + TW'(1);
          else           deb_d[r] = '0;
          if (!en[r]) begin
            state_d[r] = StOff;
          end else if (!pgs_q[r] && deb_q[r] == DebLast) begin
            state_d[r] = StFault;
            cause_d[r] = CauseDrop;
          end
        end
        StFault: begin
          if (goOut_fltSt && !en[r]) begin
            state_d[r] = StOff;
            cause_d[r] = CauseNone;
          end
        end
        default: begin
          state_d[r] = StOff;
          cause_d[r] = CauseNone;
        end
      endcase

      if (state_d[r] != state_q[r]) begin
        deb_d[r] = '0;
        tmo_d[r] = '0;
      end

      vr_en_d[r]  = (state_d[r] == StRamp) || (state_d[r] == StOn);
      pwr_gd_d[r] = (state_d[r] == StOn);
      flt_d[r]    = (state_d[r] == StFault);
    end
  end

  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      sync1_q  <= '0;
      pgs_q    <= '0;
      vr_en_q  <= '0;
      pwr_gd_q <= '0;
      flt_q    <= '0;
      for (int r = 0; r < 2; r++) begin
        state_q[r] <= StOff;
        deb_q[r]   <= '0;
        tmo_q[r]   <= '0;
        cause_q[r] <= CauseNone;
      end
    end else begin
      sync1_q  <= pg_raw;
      pgs_q    <= sync1_q;
      vr_en_q  <= vr_en_d;
      pwr_gd_q <= pwr_gd_d;
      flt_q    <= flt_d;
      for (int r = 0; r < 2; r++) begin
        state_q[r] <= state_d[r];
        deb_q[r]   <= deb_d[r];
        tmo_q[r]   <= tmo_d[r];
        cause_q[r] <= cause_d[r];
      end
    end
  end

  assign CPU_VrEN     = vr_en_q[0];
  assign MEM_VrEN     = vr_en_q[1];
  assign CPU_PwrGD    = pwr_gd_q[0];
  assign MEM_PwrGD    = pwr_gd_q[1];
  assign CPU_PwrFLT   = flt_q[0];
  assign MEM_PwrFLT   = flt_q[1];
  assign CPU_FltCause = cause_q[0];
  assign MEM_FltCause = cause_q[1];

endmodule

// File: tb/tb_pwrseq_cpu_rail_resp.sv
// Scoreboard bench for pwrseq_cpu_rail_resp: a default instance plus a short-timeout
// instance for the qualification/timeout coincidence case.
module tb_pwrseq_cpu_rail_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ResetN, CPU_PwrEN, MEM_PwrEN, goOut_fltSt, CPU_VrPG, MEM_VrPG;
  logic CPU_VrEN, MEM_VrEN, CPU_PwrGD, MEM_PwrGD, CPU_PwrFLT, MEM_PwrFLT;
  logic [1:0] CPU_FltCause, MEM_FltCause;

  logic b_rst_n, b_cpu_en, b_cpu_pg;
  logic b_cpu_vren, b_mem_vren, b_cpu_gd, b_mem_gd, b_cpu_flt, b_mem_flt;
  logic [1:0] b_cpu_cause, b_mem_cause;

  pwrseq_cpu_rail_resp #(.DEB_CYC(4), .RAMP_TMO(100)) dut (
    .CLK(clk), .ResetN(ResetN), .CPU_PwrEN(CPU_PwrEN), .MEM_PwrEN(MEM_PwrEN),
    .goOut_fltSt(goOut_fltSt), .CPU_VrPG(CPU_VrPG), .MEM_VrPG(MEM_VrPG),
    .CPU_VrEN(CPU_VrEN), .MEM_VrEN(MEM_VrEN), .CPU_PwrGD(CPU_PwrGD), .MEM_PwrGD(MEM_PwrGD),
    .CPU_PwrFLT(CPU_PwrFLT), .MEM_PwrFLT(MEM_PwrFLT),
    .CPU_FltCause(CPU_FltCause), .MEM_FltCause(MEM_FltCause)
  );

  pwrseq_cpu_rail_resp #(.DEB_CYC(4), .RAMP_TMO(8)) dut_b (
    .CLK(clk), .ResetN(b_rst_n), .CPU_PwrEN(b_cpu_en), .MEM_PwrEN(1'b0),
    .goOut_fltSt(1'b0), .CPU_VrPG(b_cpu_pg), .MEM_VrPG(1'b0),
    .CPU_VrEN(b_cpu_vren), .MEM_VrEN(b_mem_vren), .CPU_PwrGD(b_cpu_gd), .MEM_PwrGD(b_mem_gd),
    .CPU_PwrFLT(b_cpu_flt), .MEM_PwrFLT(b_mem_flt),
    .CPU_FltCause(b_cpu_cause), .MEM_FltCause(b_mem_cause)
  );

  // Observed vector: {MEM cause, CPU cause, MEM flt, CPU flt, MEM gd, CPU gd, MEM en, CPU en}
  logic [9:0] obs, obs_b;
  assign obs   = {MEM_FltCause, CPU_FltCause, MEM_PwrFLT, CPU_PwrFLT,
                  MEM_PwrGD, CPU_PwrGD, MEM_VrEN, CPU_VrEN};
  assign obs_b = {b_mem_cause, b_cpu_cause, b_mem_flt, b_cpu_flt,
                  b_mem_gd, b_cpu_gd, b_mem_vren, b_cpu_vren};

  function automatic logic [9:0] cv(logic en, logic gd, logic flt, logic [1:0] c);
    return {2'b00, c, 1'b0, flt, 1'b0, gd, 1'b0, en};
  endfunction

  function automatic logic [9:0] mv(logic en, logic gd, logic flt, logic [1:0] c);
    return {c, 2'b00, flt, 1'b0, gd, 1'b0, en, 1'b0};
  endfunction

  localparam logic [9:0] MC = 10'h0D5;
  localparam logic [9:0] MM = 10'h32A;
  localparam logic [9:0] MA = 10'h3FF;

  typedef struct {
    int         due;
    bit         sel;
    logic [9:0] mask;
    logic [9:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   cyc = 0;
  int   base = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [9:0] got, logic [9:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%b want=%b (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(int rel, string tag, bit sel, logic [9:0] mask, logic [9:0] exp);
    exp_t e;
    int   i;
    e.due = base + rel; e.sel = sel; e.mask = mask; e.exp = exp; e.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].due <= e.due) i++;
    sb.insert(i, e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      check_eq(it.tag, (it.sel ? obs_b : obs) & it.mask, it.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN = 1'b0; b_rst_n = 1'b0;
    CPU_PwrEN = 1'b0; MEM_PwrEN = 1'b0; goOut_fltSt = 1'b0;
    CPU_VrPG = 1'b0; MEM_VrPG = 1'b0;
    b_cpu_en = 1'b0; b_cpu_pg = 1'b0;
    step(3);
    base = cyc;
    push(0, "rst_all", 0, MA, 10'd0);
    push(0, "rst_b", 1, MA, 10'd0);
    ResetN = 1'b1; b_rst_n = 1'b1;
    step(1);

    // Nominal CPU power-up
    base = cyc;
    CPU_PwrEN = 1'b1;
    push(0, "t1_pre", 0, MC, cv(0, 0, 0, 2'b00));
    push(1, "t1_vren", 0, MC, cv(1, 0, 0, 2'b00));
    push(15, "t1_gd_early", 0, MC, cv(1, 0, 0, 2'b00));
    push(16, "t1_gd", 0, MC, cv(1, 1, 0, 2'b00));
    push(16, "t1_mem_idle", 0, MM, 10'd0);
    step(10);
    CPU_VrPG = 1'b1;
    step(8);

    // MEM ramp timeout and fault clear
    base = cyc;
    MEM_PwrEN = 1'b1;
    push(1, "t2_vren", 0, MM, mv(1, 0, 0, 2'b00));
    push(100, "t2_ramp", 0, MM, mv(1, 0, 0, 2'b00));
    push(101, "t2_tmo", 0, MM, mv(0, 0, 1, 2'b01));
    push(101, "t2_cpu_on", 0, MC, cv(1, 1, 0, 2'b00));
    push(108, "t2_hold", 0, MM, mv(0, 0, 1, 2'b01));
    push(111, "t2_clr", 0, MM, mv(0, 0, 0, 2'b00));
    push(111, "t2_cpu_keep", 0, MC, cv(1, 1, 0, 2'b00));
    step(105);
    goOut_fltSt = 1'b1;
    step(5);
    MEM_PwrEN = 1'b0;
    step(2);
    goOut_fltSt = 1'b0;
    step(1);

    // Bring MEM up
    base = cyc;
    MEM_VrPG = 1'b1; MEM_PwrEN = 1'b1;
    push(5, "mem_ramp", 0, MM, mv(1, 0, 0, 2'b00));
    push(6, "mem_on", 0, MM, mv(1, 1, 0, 2'b00));
    step(8);

    // 3-cycle glitch ignored
    base = cyc;
    CPU_VrPG = 1'b0;
    push(6, "t3_glitch", 0, MC, cv(1, 1, 0, 2'b00));
    push(8, "t3_glitch2", 0, MC, cv(1, 1, 0, 2'b00));
    step(3);
    CPU_VrPG = 1'b1;
    step(6);

    // 4-cycle drop faults; MEM untouched
    base = cyc;
    CPU_VrPG = 1'b0;
    push(5, "t3_pre", 0, MC, cv(1, 1, 0, 2'b00));
    push(6, "t3_drop", 0, MC, cv(0, 0, 1, 2'b10));
    push(6, "t3_mem", 0, MM, mv(1, 1, 0, 2'b00));
    push(10, "t3_flt_hold", 0, MC, cv(0, 0, 1, 2'b10));
    push(10, "t3_mem_hold", 0, MM, mv(1, 1, 0, 2'b00));
    step(4);
    CPU_VrPG = 1'b1;
    step(7);

    // One-cycle reset from CPU fault + MEM on; both re-ramp from OFF
    base = cyc;
    ResetN = 1'b0;
    push(1, "t5_rst", 0, MA, 10'd0);
    push(2, "t5_rearm", 0, MA, cv(1, 0, 0, 2'b00) | mv(1, 0, 0, 2'b00));
    push(6, "t5_ramp", 0, MA, cv(1, 0, 0, 2'b00) | mv(1, 0, 0, 2'b00));
    push(7, "t5_on", 0, MA, cv(1, 1, 0, 2'b00) | mv(1, 1, 0, 2'b00));
    step(1);
    ResetN = 1'b1;
    step(8);

    // Orderly off with simultaneous PG fall
    base = cyc;
    CPU_PwrEN = 1'b0; CPU_VrPG = 1'b0;
    push(1, "t4_off", 0, MC, 10'd0);
    push(8, "t4_nofault", 0, MC, 10'd0);
    push(8, "t4_mem", 0, MM, mv(1, 1, 0, 2'b00));
    step(9);
    base = cyc;
    CPU_VrPG = 1'b1; CPU_PwrEN = 1'b1;
    push(5, "t4_ramp", 0, MC, cv(1, 0, 0, 2'b00));
    push(6, "t4_on", 0, MC, cv(1, 1, 0, 2'b00));
    step(8);

    // Disable coincides with drop qualification: disable wins
    base = cyc;
    CPU_VrPG = 1'b0;
    push(5, "t4c_pre", 0, MC, cv(1, 1, 0, 2'b00));
    push(6, "t4c_off", 0, MC, 10'd0);
    push(9, "t4c_nofault", 0, MC, 10'd0);
    step(5);
    CPU_PwrEN = 1'b0;
    step(6);

    // RAMP_TMO=8: qualification and timeout coincide
    base = cyc;
    b_cpu_en = 1'b1;
    push(1, "t6_vren", 1, MC, cv(1, 0, 0, 2'b00));
    push(8, "t6_ramp", 1, MC, cv(1, 0, 0, 2'b00));
    push(9, "t6_coincide", 1, MC, cv(1, 1, 0, 2'b00));
    push(12, "t6_stay", 1, MC, cv(1, 1, 0, 2'b00));
    step(3);
    b_cpu_pg = 1'b1;
    step(11);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    check_eq("sb_drain", 10'(sb.size()), 10'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
